// File: rtl/shift_pkg.sv
// Shared definitions for the sequential shifter: mode codes, FSM states, mode check.
package shift_pkg;

    localparam logic [2:0] MODE_SRL = 3'b000;
    localparam logic [2:0] MODE_SLL = 3'b001;
    localparam logic [2:0] MODE_SRA = 3'b010;
    localparam logic [2:0] MODE_ROR = 3'b011;
    localparam logic [2:0] MODE_ROL = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Codes above ROL are reserved and complete with an error.
    function automatic logic is_legal_mode(input logic [2:0] mode);
        return (mode <= MODE_ROL);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational shift of the working word by 0..STEP positions, reporting the last bit out.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    parameter int CNT_W = 1
) (
    input  logic [WIDTH-1:0] word,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] cnt,
    input  logic             fill,
    output logic [WIDTH-1:0] res,
    output logic             last_out
);

    // Unrolled chain of single-bit shifts; only the first cnt stages are active.
    always_comb begin
        res      = word;
        last_out = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            if (i < int'(cnt)) begin
                case (mode)
                    MODE_SRL, MODE_SRA: begin
                        last_out = res[0];
                        res      = {fill, res[WIDTH-1:1]};
                    end
                    MODE_SLL: begin
                        last_out = res[WIDTH-1];
                        res      = {res[WIDTH-2:0], 1'b0};
                    end
                    MODE_ROR: begin
                        last_out = res[0];
                        res      = {res[0], res[WIDTH-1:1]};
                    end
                    MODE_ROL: begin
                        last_out = res[WIDTH-1];
                        res      = {res[WIDTH-2:0], res[WIDTH-1]};
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/shift_unit_seq.sv
// Sequential shifter: accepts one operand, shifts up to STEP bits per clock, pulses on completion.
module shift_unit_seq
    import shift_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int AMT_WIDTH = $clog2(WIDTH),
    parameter int STEP      = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 Operand_Sel,
    input  logic [2:0]           Shift_Mode,
    input  logic [AMT_WIDTH-1:0] Shift_Amt,
    input  logic                 Shift_Enable,
    output logic                 Shift_Busy,
    output logic [WIDTH-1:0]     Shift_OUT,
    output logic                 Shift_Flag,
    output logic                 Shift_Carry,
    output logic                 Shift_Err
);

    localparam int CNT_W = $clog2(STEP + 1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     work_q;
    logic [AMT_WIDTH-1:0] rem_q;
    logic [2:0]           mode_q;
    logic                 fill_q;
    logic                 illegal_q;
    logic                 last_q;
    logic [CNT_W-1:0]     step_n;
    logic [WIDTH-1:0]     step_res;
    logic                 step_out;
    logic [WIDTH-1:0]     sel_op;

    assign sel_op     = Operand_Sel ? B : A;
    assign Shift_Busy = (state_q != S_IDLE);

    // Positions to move this cycle: min(STEP, remaining).
    always_comb begin
        step_n = CNT_W'(rem_q);
        if (int'(rem_q) >= STEP) step_n = CNT_W'(STEP);
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .CNT_W (CNT_W)
    ) u_step (
        .word     (work_q),
        .mode     (mode_q),
        .cnt      (step_n),
        .fill     (fill_q),
        .res      (step_res),
        .last_out (step_out)
    );

    // FSM state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next state: zero amount or illegal mode skip straight to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (Shift_Enable) begin
                    if (Shift_Amt == '0 || !is_legal_mode(Shift_Mode)) state_d = S_DONE;
                    else                                                state_d = S_SHIFT;
                end
            end
            S_SHIFT: if (rem_q == AMT_WIDTH'(step_n)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Working register, remaining count and latched operation context.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            work_q    <= '0;
            rem_q     <= '0;
            mode_q    <= MODE_SRL;
            fill_q    <= 1'b0;
            illegal_q <= 1'b0;
            last_q    <= 1'b0;
        end else if (state_q == S_IDLE && Shift_Enable) begin
            work_q    <= sel_op;
            rem_q     <= Shift_Amt;
            mode_q    <= Shift_Mode;
            fill_q    <= (Shift_Mode == MODE_SRA) & sel_op[WIDTH-1];
            illegal_q <= !is_legal_mode(Shift_Mode);
            last_q    <= 1'b0;
        end else if (state_q == S_SHIFT) begin
            work_q <= step_res;
            rem_q  <= rem_q - AMT_WIDTH'(step_n);
            last_q <= step_out;
        end
    end

    // Result registers update only on the completion edge; flag is a single-cycle pulse.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Shift_OUT   <= '0;
            Shift_Flag  <= 1'b0;
            Shift_Carry <= 1'b0;
            Shift_Err   <= 1'b0;
        end else begin
            Shift_Flag <= (state_q == S_DONE);
            if (state_q == S_DONE) begin
                Shift_OUT   <= illegal_q ? '0 : work_q;
                Shift_Carry <= last_q;
                Shift_Err   <= illegal_q;
            end
        end
    end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Bench for shift_unit_seq: STEP=1 and STEP=4 instances, directed table, corner sequences, random ops.
module tb_shift_unit_seq;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] A = '0, B = '0;
    logic        Operand_Sel = 1'b0;
    logic [2:0]  Shift_Mode = '0;
    logic [3:0]  Shift_Amt = '0;
    logic        en1 = 1'b0, en4 = 1'b0;

    logic        busy1, flag1, carry1, err1;
    logic [15:0] out1;
    logic        busy4, flag4, carry4, err4;
    logic [15:0] out4;

    int n_vec = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    shift_unit_seq #(.WIDTH(16), .AMT_WIDTH(4), .STEP(1)) dut1 (
        .CLK(CLK), .RST(RST), .A(A), .B(B), .Operand_Sel(Operand_Sel),
        .Shift_Mode(Shift_Mode), .Shift_Amt(Shift_Amt), .Shift_Enable(en1),
        .Shift_Busy(busy1), .Shift_OUT(out1), .Shift_Flag(flag1),
        .Shift_Carry(carry1), .Shift_Err(err1)
    );

    shift_unit_seq #(.WIDTH(16), .AMT_WIDTH(4), .STEP(4)) dut4 (
        .CLK(CLK), .RST(RST), .A(A), .B(B), .Operand_Sel(Operand_Sel),
        .Shift_Mode(Shift_Mode), .Shift_Amt(Shift_Amt), .Shift_Enable(en4),
        .Shift_Busy(busy4), .Shift_OUT(out4), .Shift_Flag(flag4),
        .Shift_Carry(carry4), .Shift_Err(err4)
    );

    typedef struct {
        int          d;
        logic        sel;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  mode;
        logic [3:0]  amt;
        logic [15:0] e_out;
        logic        e_carry;
        logic        e_err;
        int          e_k;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: shift by the whole amount at once with plain operators.
    function automatic void model(input logic [15:0] op, input logic [2:0] mode, input int amt,
                                  output logic [15:0] r, output logic c, output logic e);
        r = op; c = 1'b0; e = 1'b0;
        case (mode)
            3'd0: begin r = op >> amt;                      if (amt > 0) c = op[amt-1];  end
            3'd1: begin r = op << amt;                      if (amt > 0) c = op[16-amt]; end
            3'd2: begin r = $signed(op) >>> amt;            if (amt > 0) c = op[amt-1];  end
            3'd3: begin r = (op >> amt) | (op << (16-amt)); if (amt > 0) c = r[15];      end
            3'd4: begin r = (op << amt) | (op >> (16-amt)); if (amt > 0) c = r[0];       end
            default: begin r = '0; e = 1'b1; end
        endcase
    endfunction

    function automatic int model_k(input logic [2:0] mode, input int amt, input int step);
        if (amt == 0 || mode > 3'd4) return 1;
        return (amt + step - 1) / step + 1;
    endfunction

    // Drives one request and returns #1 after the accept edge.
    task automatic start_op(input int d, input logic sel, input logic [15:0] a, input logic [15:0] b,
                            input logic [2:0] mode, input logic [3:0] amt);
        @(negedge CLK);
        A = a; B = b; Operand_Sel = sel; Shift_Mode = mode; Shift_Amt = amt;
        if (d == 1) en1 = 1'b1; else en4 = 1'b1;
        @(posedge CLK); #1;
        en1 = 1'b0; en4 = 1'b0;
    endtask

    // Counts edges after accept until the flag is seen (bounded).
    task automatic wait_done(input int d, output logic [15:0] o, output logic c, output logic e,
                             output int k);
        logic f;
        k = 0;
        for (int i = 0; i < 64; i++) begin
            @(posedge CLK); #1;
            k++;
            f = (d == 1) ? flag1 : flag4;
            if (f) break;
        end
        o = (d == 1) ? out1 : out4;
        c = (d == 1) ? carry1 : carry4;
        e = (d == 1) ? err1 : err4;
    endtask

    task automatic run_op(input int d, input logic sel, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] mode, input logic [3:0] amt,
                          output logic [15:0] o, output logic c, output logic e, output int k);
        start_op(d, sel, a, b, mode, amt);
        wait_done(d, o, c, e, k);
    endtask

    initial begin
        vec_t        tbl[9];
        logic [15:0] o, r_exp;
        logic        c, e, c_exp, e_exp;
        int          k, seen;

        tbl[0] = '{1, 1'b0, 16'h8005, 16'h0000, 3'd0, 4'd3,  16'h1000, 1'b1, 1'b0, 4};
        tbl[1] = '{4, 1'b1, 16'h1111, 16'hF000, 3'd2, 4'd4,  16'hFF00, 1'b0, 1'b0, 2};
        tbl[2] = '{1, 1'b0, 16'h8001, 16'h0000, 3'd4, 4'd1,  16'h0003, 1'b1, 1'b0, 2};
        tbl[3] = '{1, 1'b0, 16'h0003, 16'h0000, 3'd3, 4'd1,  16'h8001, 1'b1, 1'b0, 2};
        tbl[4] = '{1, 1'b0, 16'h1234, 16'h0000, 3'd0, 4'd0,  16'h1234, 1'b0, 1'b0, 1};
        tbl[5] = '{1, 1'b0, 16'h1234, 16'h0000, 3'd5, 4'd3,  16'h0000, 1'b0, 1'b1, 1};
        tbl[6] = '{1, 1'b0, 16'h0001, 16'h0000, 3'd1, 4'd5,  16'h0020, 1'b0, 1'b0, 6};
        tbl[7] = '{4, 1'b0, 16'h8005, 16'h0000, 3'd0, 4'd7,  16'h0100, 1'b0, 1'b0, 3};
        tbl[8] = '{4, 1'b0, 16'h8001, 16'h0000, 3'd4, 4'd15, 16'hC000, 1'b0, 1'b0, 5};

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_busy", busy1, 0);
        chk("rst_out", out1, 0);
        chk("rst_flag", flag1, 0);
        chk("rst_carry", carry1, 0);
        chk("rst_err", err1, 0);
        @(negedge CLK); RST = 1'b1;

        // Directed table
        foreach (tbl[i]) begin
            run_op(tbl[i].d, tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].mode, tbl[i].amt, o, c, e, k);
            chk($sformatf("tbl%0d_out", i), o, tbl[i].e_out);
            chk($sformatf("tbl%0d_carry", i), c, tbl[i].e_carry);
            chk($sformatf("tbl%0d_err", i), e, tbl[i].e_err);
            chk($sformatf("tbl%0d_k", i), k, tbl[i].e_k);
        end

        // Enable pulse during busy is ignored; enable in flag cycle starts the next op
        start_op(1, 1'b0, 16'h0001, 16'h0000, 3'd1, 4'd5);
        k = 0;
        for (int i = 0; i < 64; i++) begin
            @(posedge CLK); #1;
            k++;
            if (k == 1) begin
                A = 16'hFFFF; Shift_Mode = 3'd4; Shift_Amt = 4'd1; en1 = 1'b1;
            end else if (k == 2) begin
                en1 = 1'b0;
            end
            if (flag1) break;
        end
        chk("ign_k", k, 6);
        chk("ign_out", out1, 16'h0020);
        chk("ign_busy", busy1, 0);
        A = 16'h0003; Shift_Mode = 3'd4; Shift_Amt = 4'd1; en1 = 1'b1;
        @(posedge CLK); #1;
        en1 = 1'b0;
        chk("b2b_busy", busy1, 1);
        chk("b2b_flag_low", flag1, 0);
        chk("b2b_out_hold", out1, 16'h0020);
        wait_done(1, o, c, e, k);
        chk("b2b_k", k, 2);
        chk("b2b_out", o, 16'h0006);
        chk("b2b_carry", c, 0);

        // Illegal mode, then a legal op: Err holds until the next completion, then clears
        run_op(1, 1'b0, 16'hABCD, 16'h0000, 3'd7, 4'd9, o, c, e, k);
        chk("ill_err", e, 1);
        chk("ill_out", o, 0);
        chk("ill_k", k, 1);
        start_op(1, 1'b0, 16'h8001, 16'h0000, 3'd4, 4'd1);
        chk("ill_err_hold", err1, 1);
        wait_done(1, o, c, e, k);
        chk("clr_err", e, 0);
        chk("clr_out", o, 16'h0003);
        chk("clr_carry", c, 1);

        // Reset at edge 2 of a 10-step shift
        start_op(1, 1'b0, 16'hFFFF, 16'h0000, 3'd0, 4'd10);
        repeat (2) begin @(posedge CLK); #1; end
        RST = 1'b0;
        #1;
        chk("mrst_busy", busy1, 0);
        chk("mrst_out", out1, 0);
        chk("mrst_carry", carry1, 0);
        chk("mrst_flag", flag1, 0);
        @(negedge CLK); RST = 1'b1;
        seen = 0;
        repeat (12) begin @(posedge CLK); #1; if (flag1) seen++; end
        chk("mrst_noflag", seen, 0);
        run_op(1, 1'b0, 16'h8005, 16'h0000, 3'd0, 4'd3, o, c, e, k);
        chk("mrst_fresh_out", o, 16'h1000);
        chk("mrst_fresh_k", k, 4);

        // Randomized ops on both instances against the reference
        for (int n = 0; n < 60; n++) begin
            int          d;
            logic        sel;
            logic [15:0] a, b;
            logic [2:0]  mode;
            logic [3:0]  amt;
            d    = (n % 2 == 0) ? 1 : 4;
            sel  = 1'($urandom_range(0, 1));
            a    = 16'($urandom);
            b    = 16'($urandom);
            mode = 3'($urandom_range(0, 7));
            amt  = 4'($urandom_range(0, 15));
            model(sel ? b : a, mode, int'(amt), r_exp, c_exp, e_exp);
            run_op(d, sel, a, b, mode, amt, o, c, e, k);
            chk($sformatf("rnd%0d_out", n), o, r_exp);
            chk($sformatf("rnd%0d_carry", n), c, c_exp);
            chk($sformatf("rnd%0d_err", n), e, e_exp);
            chk($sformatf("rnd%0d_k", n), k, model_k(mode, int'(amt), d));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
